// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the counter key controller: FSM encodings, default
// timing parameters and the bit position of each key in the key vector.
package counter_ctrl_pkg;

  localparam int DB_CYCLES_DEF = 16;
  localparam int PRESCALE_DEF  = 8;

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LDP  = 2'd2;

  localparam int NUM_KEYS     = 3;
  localparam int KEY_RUN_IDX  = 0;
  localparam int KEY_DIR_IDX  = 1;
  localparam int KEY_LOAD_IDX = 2;

endpackage

// File: rtl/key_debounce.sv
// One push-button path: 2-FF synchroniser, stability counter that flips the
// debounced level after DB_CYCLES agreeing samples, and a rising-edge press pulse.
module key_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_dly_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;

  // Any sample that agrees with the current level restarts the stability window.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_inc == CW'(DB_CYCLES)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= key_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/counter_key_ctrl.sv
// Control stage for the 4-bit reversible counter: debounced keys, RUN/STOP/LOAD FSM,
// EN prescaler, direction toggle and preset latch. Define ONESHOT_EN to halt on CO_IN.
module counter_key_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int PRESCALE  = PRESCALE_DEF
) (
  input  logic       CLK,
  input  logic       MR,
  input  logic       KEY_RUN,
  input  logic       KEY_DIR,
  input  logic       KEY_LOAD,
  input  logic [3:0] SW_D,
  input  logic       CO_IN,
  output logic       EN,
  output logic       UpDown,
  output logic       LOAD,
  output logic [3:0] D
);

  localparam int             PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] press;
  logic                press_run;
  logic                press_dir;
  logic                press_load;
  logic                halt;
  logic                terminal;

  logic [1:0]    state_q,    state_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic          en_q,       en_d;
  logic          load_n_q,   load_n_d;
  logic          updown_q,   updown_d;
  logic [3:0]    d_q,        d_d;

  assign key_raw[KEY_RUN_IDX]  = KEY_RUN;
  assign key_raw[KEY_DIR_IDX]  = KEY_DIR;
  assign key_raw[KEY_LOAD_IDX] = KEY_LOAD;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
        .clk     (CLK),
        .srst    (MR),
        .key_raw (key_raw[gi]),
        .press   (press[gi])
      );
    end
  endgenerate

  assign press_run  = press[KEY_RUN_IDX];
  assign press_dir  = press[KEY_DIR_IDX];
  assign press_load = press[KEY_LOAD_IDX];

`ifdef ONESHOT_EN
  assign halt = CO_IN;
`else
  logic unused_co_in;
  assign unused_co_in = CO_IN;
  assign halt         = 1'b0;
`endif

  assign terminal = (state_q == ST_RUN) && (prescale_q == PS_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (press_load)     state_d = ST_LDP;
        else if (press_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press_load)            state_d = ST_LDP;
        else if (press_run)        state_d = ST_STOP;
        else if (terminal && halt) state_d = ST_STOP;
      end
      ST_LDP:  state_d = press_load ? ST_LDP : ST_STOP;
      default: state_d = ST_STOP;
    endcase

    prescale_d = ((state_q == ST_RUN) && (prescale_q != PS_LAST)) ? prescale_q + 1'b1 : '0;

    // A strobe is only issued if the FSM stays in RUN, so leaving RUN swallows it.
    en_d     = terminal && (state_d == ST_RUN);
    load_n_d = (state_d != ST_LDP);
    d_d      = (state_d == ST_LDP) ? SW_D : d_q;
    updown_d = updown_q ^ press_dir;
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q    <= ST_STOP;
      prescale_q <= '0;
      en_q       <= 1'b0;
      load_n_q   <= 1'b1;
      updown_q   <= 1'b0;
      d_q        <= 4'h0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      en_q       <= en_d;
      load_n_q   <= load_n_d;
      updown_q   <= updown_d;
      d_q        <= d_d;
    end
  end

  assign EN     = en_q;
  assign LOAD   = load_n_q;
  assign UpDown = updown_q;
  assign D      = d_q;

endmodule

// File: tb/tb_counter_key_ctrl.sv
// Scoreboard bench for counter_key_ctrl with DB_CYCLES=4, PRESCALE=4; a small
// 4-bit counter model closes the CO_IN loop for the terminal-count scenario.
module tb_counter_key_ctrl;

  localparam logic [2:0] M_RUN  = 3'b001;
  localparam logic [2:0] M_DIR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b100;
  localparam int K_EN   = 0;
  localparam int K_LOAD = 1;

  logic       CLK = 1'b0;
  logic       MR = 1'b1;
  logic       KEY_RUN = 1'b0;
  logic       KEY_DIR = 1'b0;
  logic       KEY_LOAD = 1'b0;
  logic [3:0] SW_D = 4'h0;
  logic       CO_IN;
  logic       EN;
  logic       UpDown;
  logic       LOAD;
  logic [3:0] D;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;

  ev_t  sb[$];
  ev_t  mon_e;
  int   mon_kind;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  bit   co_en = 1'b0;
  logic [3:0] q_model = 4'h0;

  counter_key_ctrl #(
    .DB_CYCLES (4),
    .PRESCALE  (4)
  ) dut (
    .CLK      (CLK),
    .MR       (MR),
    .KEY_RUN  (KEY_RUN),
    .KEY_DIR  (KEY_DIR),
    .KEY_LOAD (KEY_LOAD),
    .SW_D     (SW_D),
    .CO_IN    (CO_IN),
    .EN       (EN),
    .UpDown   (UpDown),
    .LOAD     (LOAD),
    .D        (D)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Downstream 4-bit reversible counter.
  always @(posedge CLK) begin
    if (MR)                q_model <= 4'h0;
    else if (LOAD == 1'b0) q_model <= D;
    else if (EN == 1'b1)   q_model <= UpDown ? q_model - 4'd1 : q_model + 4'd1;
  end

  assign CO_IN = co_en && (UpDown ? (q_model == 4'h0) : (q_model == 4'hF));

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int data);
    sb.push_back('{kind: kind, cyc: c, data: data});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic set_keys(input logic [2:0] mask, input logic val);
    if (mask[0]) KEY_RUN  = val;
    if (mask[1]) KEY_DIR  = val;
    if (mask[2]) KEY_LOAD = val;
  endtask

  task automatic tap(input logic [2:0] mask, input int t, input int hold);
    wait_cyc(t);
    set_keys(mask, 1'b1);
    wait_cyc(t + hold);
    set_keys(mask, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (mon_on && (EN === 1'b1 || LOAD === 1'b0)) begin
      mon_kind = (LOAD === 1'b0) ? K_LOAD : K_EN;
      $display("strobe cycle=%0d kind=%s UpDown=%0d D=%0h", cyc,
               (mon_kind == K_LOAD) ? "LOAD" : "EN", UpDown, D);
      if (EN === 1'b1 && LOAD === 1'b0) check("en_with_load", 1, 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe_cycle", cyc, -1);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", mon_kind, mon_e.kind);
        check("strobe_cycle", cyc, mon_e.cyc);
        if (mon_kind == K_LOAD) check("load_d", int'(D), mon_e.data);
        else                    check("en_dir", int'(UpDown), mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, g, r, s, r2, z;

    // Reset held for two edges while keys toggle.
    @(negedge CLK);
    set_keys(3'b111, 1'b1);
    wait_cyc(1);
    KEY_DIR = 1'b0;
    wait_cyc(2);
    MR = 1'b0;
    set_keys(3'b111, 1'b0);
    check("rst_en", int'(EN), 0);
    check("rst_load", int'(LOAD), 1);
    check("rst_updown", int'(UpDown), 0);
    check("rst_d", int'(D), 0);
    mon_on = 1'b1;
    wait_cyc(20);
    check("idle_after_reset_pending", sb.size(), 0);

    // Bouncing RUN press, 20 cycles running, then RUN again to stop.
    t0 = 22;
    for (int k = 0; k < 4; k++) push_ev(K_EN, t0 + 11 + 4 * k, 0);
    KEY_RUN = 1'b1;
    wait_cyc(21);
    KEY_RUN = 1'b0;
    wait_cyc(22);
    KEY_RUN = 1'b1;
    wait_cyc(t0 + 6);
    KEY_RUN = 1'b0;
    tap(M_RUN, t0 + 20, 6);
    wait_cyc(t0 + 40);
    check("run_phase_pending", sb.size(), 0);

    // Glitch shorter than the debounce window.
    g = t0 + 40;
    tap(M_RUN, g, 3);
    wait_cyc(g + 25);
    check("glitch_pending", sb.size(), 0);

    // LOAD during RUN: the due EN is swallowed, then STOP.
    r = g + 25;
    SW_D = 4'hA;
    push_ev(K_EN, r + 11, 0);
    push_ev(K_EN, r + 15, 0);
    push_ev(K_LOAD, r + 19, 4'hA);
    tap(M_RUN, r, 6);
    tap(M_LOAD, r + 12, 6);
    wait_cyc(r + 30);
    check("d_hold_a", int'(D), 4'hA);
    check("load_idle", int'(LOAD), 1);
    check("load_phase_pending", sb.size(), 0);

    // LOAD and RUN pressed together: LDP wins, no counting follows.
    s = r + 40;
    wait_cyc(s);
    SW_D = 4'h5;
    push_ev(K_LOAD, s + 7, 4'h5);
    tap(M_RUN | M_LOAD, s, 6);
    wait_cyc(s + 9);
    SW_D = 4'h3;
    wait_cyc(s + 30);
    check("d_hold_5", int'(D), 4'h5);
    check("both_phase_pending", sb.size(), 0);

    // Direction toggles while running.
    r2 = s + 30;
    for (int k = 0; k < 7; k++) push_ev(K_EN, r2 + 11 + 4 * k, (k >= 2 && k <= 5) ? 1 : 0);
    tap(M_RUN, r2, 6);
    tap(M_DIR, r2 + 10, 6);
    check("dir_before", int'(UpDown), 0);
    wait_cyc(r2 + 17);
    check("dir_after", int'(UpDown), 1);
    tap(M_DIR, r2 + 26, 6);
    KEY_RUN = 1'b1;
    check("dir_before2", int'(UpDown), 1);
    wait_cyc(r2 + 33);
    check("dir_after2", int'(UpDown), 0);
    wait_cyc(r2 + 38);
    KEY_RUN = 1'b0;
    wait_cyc(r2 + 50);
    check("dir_phase_pending", sb.size(), 0);

    // Counter preset to 14 counting up, CO_IN fed back.
    z = r2 + 50;
    wait_cyc(z);
    co_en = 1'b1;
    SW_D = 4'hE;
    push_ev(K_LOAD, z + 7, 4'hE);
    push_ev(K_EN, z + 21, 0);
`ifndef ONESHOT_EN
    push_ev(K_EN, z + 25, 0);
`endif
    tap(M_LOAD, z, 6);
    tap(M_RUN, z + 10, 6);
`ifndef ONESHOT_EN
    tap(M_RUN, z + 20, 6);
`endif
    wait_cyc(z + 35);
`ifdef ONESHOT_EN
    check("q_terminal", int'(q_model), 15);
`else
    check("q_terminal", int'(q_model), 0);
`endif
    check("final_pending", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
